mips_mem_arbiter: RTL

- Arbitrates a single-port, fixed-latency unified memory between the MIPS instruction-fetch (IF) stage and the data (MEM) stage.
- Sequences each access over MEM_LAT cycles and returns read data with a one-cycle ready pulse.
- Drives a stall signal that freezes the pipeline while any access is outstanding.
- Sits between the core datapath and the memory model.

---
 rtl/mips_mem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one fixed-latency memory port between fetch and data.
// Alternates grants under contention; stalls the pipeline while busy.
module mips_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;

    logic done;
    logic decide;
    logic cand_i;
    logic cand_d;
    logic pick_i;
    logic pick_d;

    always_comb begin
        done   = (state != IDLE) && (cnt == '0);
        decide = (state == IDLE) || done;
        // The requester finishing at this edge yields to the other one
        cand_i = if_req && !(done && state == BUSY_I);
        cand_d = d_req && !(done && state == BUSY_D);
        pick_d = cand_d && (!cand_i || last_grant == GNT_I);
        pick_i = cand_i && !pick_d;
    end

    assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= GNT_I;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            if (done) begin
                if (state == BUSY_I) begin
                    if_rdata <= mem_rdata;
                    if_ready <= 1'b1;
                end else begin
                    if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                    d_ready <= 1'b1;
                end
            end

            if (decide) begin
                if (pick_d) begin
                    state      <= BUSY_D;
                    cnt        <= LAT_M1;
                    last_grant <= GNT_D;
                    mem_en     <= 1'b1;
                    mem_we     <= d_we;
                    mem_addr   <= d_addr;
                    mem_wdata  <= d_wdata;
                end else if (pick_i) begin
                    state      <= BUSY_I;
                    cnt        <= LAT_M1;
                    last_grant <= GNT_I;
                    mem_en     <= 1'b1;
                    mem_we     <= 1'b0;
                    mem_addr   <= if_addr;
                end else begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
